// File: rtl/regfile_bank_if.sv
// Purpose : bus bundle between the decode stage / ALU operand latches and regfile_bank.
// Signals : wr_en/wr_addr/wr_data   - write request (decode -> regfile)
//           rd_addr_a/rd_addr_b     - read indices (decode -> regfile)
//           rd_data_a/rd_data_b     - registered read data (regfile -> ALU latches)
//           busy                    - clear sweep in progress, writes are discarded
//           wr_drop                 - one-cycle pulse per discarded write request
interface regfile_bank_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy;
    logic              wr_drop;

    // Requester side (decode stage / testbench)
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, busy, wr_drop
    );

    // Register file side
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, busy, wr_drop
    );
endinterface

// File: rtl/regfile_bank.sv
// Purpose : DEPTH x DATA_W register file, one write port, two registered read
//           ports with same-cycle write bypass, optional hardwired-zero r0 and
//           a post-reset sweep that clears every register.
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-high; restarts the clear sweep
//           bus   - regfile_bank_if slave modport (write port, read ports,
//                   busy and wr_drop status)
module regfile_bank #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic           clk,
    input logic           reset,
    regfile_bank_if.slave bus
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_in_clear;
    logic              w_wr_to_zero;
    logic              w_wr_accept;
    logic              w_sweep_last;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rd_next_a;
    logic [DATA_W-1:0] w_rd_next_b;

    assign w_in_clear   = (r_state == ST_CLEAR);
    assign w_wr_to_zero = ZERO_REG && (bus.wr_addr == '0);
    assign w_wr_accept  = !w_in_clear && bus.wr_en && !w_wr_to_zero;
    assign w_sweep_last = (r_idx == IDX_W'(DEPTH - 1));

    // Single array write port shared by the sweep and the normal write path;
    // reset cycles leave the array untouched.
    assign w_mem_we   = !reset && (w_in_clear || w_wr_accept);
    assign w_mem_addr = w_in_clear ? r_idx[ADDR_W-1:0] : bus.wr_addr;
    assign w_mem_data = w_in_clear ? '0 : bus.wr_data;

    // Read muxes: hardwired zero wins over bypass, bypass wins over storage.
    assign w_rd_next_a = (ZERO_REG && (bus.rd_addr_a == '0))               ? '0 :
                         (w_wr_accept && (bus.wr_addr == bus.rd_addr_a))   ? bus.wr_data :
                                                                             r_mem[bus.rd_addr_a];
    assign w_rd_next_b = (ZERO_REG && (bus.rd_addr_b == '0))               ? '0 :
                         (w_wr_accept && (bus.wr_addr == bus.rd_addr_b))   ? bus.wr_data :
                                                                             r_mem[bus.rd_addr_b];

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Sequencer FSM with registered status and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_wr_drop   <= 1'b0;
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_idx       <= r_idx + IDX_W'(1);
            r_wr_drop   <= bus.wr_en;
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            if (w_sweep_last) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
            end
        end else begin
            r_wr_drop   <= bus.wr_en && w_wr_to_zero;
            r_rd_data_a <= w_rd_next_a;
            r_rd_data_b <= w_rd_next_b;
        end
    end

    assign bus.rd_data_a = r_rd_data_a;
    assign bus.rd_data_b = r_rd_data_b;
    assign bus.busy      = r_busy;
    assign bus.wr_drop   = r_wr_drop;

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised register-file block for the RISC datapath: one write port with internally decoded write enables, two registered read ports with internally multiplexed outputs, and an optional hardwired-zero register 0. After every reset, an internal sequencer clears all registers, so software sees a zeroed file. The block sits between the decode stage (addresses) and the ALU operand latches (read data).

## Interface
- DATA_W, default 8: register width in bits.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  registered read data, port A.
- rd_data_b  out  DATA_W  registered read data, port B.
- busy  out  1  high while the clear sweep runs; the block accepts no writes while busy is high.
- wr_drop  out  1  one-cycle pulse when a write request is discarded.

## Operation
- Storage: DEPTH x DATA_W flops. There is no reset on the array; the sweep clears it.
- FSM states:
  - CLEAR: idx counter, ADDR_W+1 bits.
    - Each cycle, write 0 to reg[idx] and increment idx.
    - When idx == DEPTH-1 is written, go to RUN.
  - RUN: normal operation.
- reset high: state <= CLEAR, idx <= 0, rd_data_a/b <= 0, wr_drop <= 0. The array is not touched during reset cycles.
- Reset asserted mid-sweep or in RUN restarts the sweep from idx 0.
- busy = (state == CLEAR), registered. busy reads 1 during and immediately after reset.
- Write in RUN: when wr_en=1, reg[wr_addr] <= wr_data, except when ZERO_REG=1 and wr_addr=0. That case is discarded and pulses wr_drop.
- Write in CLEAR: when wr_en=1, the write is discarded and wr_drop pulses the next cycle. The sweep continues unaffected.
- Read in RUN, per port: rd_data_x <= value of reg[rd_addr_x] at the edge, with same-cycle write bypass.
  - Bypass applies when wr_en=1, the write is accepted, and wr_addr == rd_addr_x. Then rd_data_x <= wr_data (new value, not old).
  - When ZERO_REG=1 and rd_addr_x=0: rd_data_x <= 0 regardless of bypass.
- Read in CLEAR: rd_data_a/b <= 0.
- Both ports may address the same register; both return the identical value.
- No arithmetic on data. Addresses are always in range because DEPTH = 2**ADDR_W.

## Timing
- Reset released at edge E0; cycles are counted from E0.
  - Sweep writes idx 0 at E1 through idx DEPTH-1 at E_DEPTH.
  - busy falls after E_DEPTH.
  - The first accepted write occurs at E_(DEPTH+1).
- Read latency: 1 cycle. rd_addr presented in cycle n gives rd_data valid in cycle n+1.
- Write-to-read:
  - Same-cycle address match returns the new data in n+1 via bypass.
  - A later read sees the stored value.
- wr_drop: high exactly one cycle (cycle n+1) per discarded request in cycle n. Back-to-back discards keep it high.
- rd_data holds its last value when the read address does not change and no matching write occurs.

## Test plan
- Reset sweep, DATA_W=8, ADDR_W=5: pre-load garbage via backdoor, pulse reset 1 cycle -> busy=1 for exactly 32 cycles after release; then reads of regs 0..31 all return 8'h00.
- Basic write/read: write 8'hA5 to r7, next cycle read A=r7, B=r7 -> both ports return 8'hA5 one cycle after the address is applied.
- Bypass: in one cycle, wr_en=1, wr_addr=3, wr_data=8'h3C, rd_addr_a=3; r3 previously 8'h11 -> rd_data_a=8'h3C next cycle.
- Zero register, ZERO_REG=1: write 8'hFF to r0 -> wr_drop pulses 1 cycle and r0 reads 8'h00. Same test with ZERO_REG=0 -> r0 reads 8'hFF, no wr_drop.
- Write during sweep: wr_en=1 to r5 with 8'h77 at cycle 10 after reset release -> wr_drop=1 at cycle 11, sweep completes on schedule, r5 reads 8'h00.
- Reset mid-sweep: assert reset at cycle 20 of the sweep for 2 cycles -> busy stays high, sweep restarts at idx 0, busy falls 32 cycles after the second release, all registers read 0.
